// File: rtl/fifo_fill_ctrl.sv
// Read-side FIFO fill controller: issues full-burst and tail read requests to the
// AXI read engine while the read-data FIFO has room, until the frame budget is spent.
module fifo_fill_ctrl #(
  parameter int               DEPTH     = 1024,
  parameter int               CW        = 11,
  parameter int               BURST_LEN = 128,
  parameter int               LSIZE     = 9,
  parameter int               TSIZE     = 24,
  parameter logic [TSIZE-1:0] TIMEOUT   = 24'hFFF000
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             enable,
  input  logic             f_rst_status,
  input  logic             frame_start,
  input  logic [TSIZE-1:0] frame_len,
  input  logic [CW-1:0]    count,
  input  logic             fifo_empty,
  input  logic             resp,
  input  logic             done,
  output logic             burst_req,
  output logic             tail_req,
  output logic [LSIZE-1:0] req_len,
  output logic             burst_done,
  output logic             tail_done,
  output logic             frame_done,
  output logic             rst_chain,
  output logic             busy,
  output logic [TSIZE-1:0] remain
);

  localparam int CMPW = ((CW + 1) > LSIZE) ? (CW + 1) : LSIZE;
  localparam logic [TSIZE-1:0] BL_T    = TSIZE'(BURST_LEN);
  localparam logic [LSIZE-1:0] BL_L    = LSIZE'(BURST_LEN);
  localparam logic [CW:0]      DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [TSIZE-1:0] TO_LAST = TIMEOUT - 1'b1;

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT_DONE, FSH, TIME_ERR, RESET_CHAIN
  } state_t;

  state_t           r_state;
  logic [TSIZE-1:0] r_remain;
  logic [LSIZE-1:0] r_req_len;
  logic [TSIZE-1:0] r_tcnt;
  logic             r_tail;

  logic [CW:0]      w_fill;
  logic [CW:0]      w_free;
  logic [LSIZE-1:0] w_next_len;
  logic             w_is_tail;
  logic             w_fits;
  logic             w_to;
  logic [TSIZE-1:0] w_after;

  // An over-range fill level is treated as a full FIFO.
  assign w_fill     = {1'b0, count};
  assign w_free     = (w_fill > DEPTH_C) ? '0 : (DEPTH_C - w_fill);
  assign w_is_tail  = (r_remain < BL_T);
  assign w_next_len = w_is_tail ? r_remain[LSIZE-1:0] : BL_L;
  assign w_fits     = (CMPW'(w_free) >= CMPW'(w_next_len));
  assign w_to       = (r_tcnt == TO_LAST);
  assign w_after    = r_remain - TSIZE'(r_req_len);

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state   <= IDLE;
      r_remain  <= '0;
      r_req_len <= '0;
      r_tcnt    <= '0;
      r_tail    <= 1'b0;
    end else if (f_rst_status) begin
      r_state  <= IDLE;
      r_remain <= '0;
      r_tcnt   <= '0;
    end else begin
      // The timeout counter spans the whole REQ + WAIT_DONE handshake.
      if (r_state == REQ || r_state == WAIT_DONE) r_tcnt <= r_tcnt + 1'b1;
      else                                         r_tcnt <= '0;
      case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_remain <= frame_len;
          end else if (enable && (r_remain != '0) && w_fits) begin
            r_state   <= REQ;
            r_req_len <= w_next_len;
            r_tail    <= w_is_tail;
          end
        end
        REQ: begin
          if (resp && done) begin
            r_state  <= FSH;
            r_remain <= w_after;
          end else if (resp) begin
            r_state <= WAIT_DONE;
          end else if (w_to) begin
            r_state <= TIME_ERR;
          end
        end
        WAIT_DONE: begin
          if (done) begin
            r_state  <= FSH;
            r_remain <= w_after;
          end else if (w_to) begin
            r_state <= TIME_ERR;
          end
        end
        FSH:      r_state <= IDLE;
        TIME_ERR: begin
          r_remain <= '0;
          r_state  <= RESET_CHAIN;
        end
        RESET_CHAIN: if (fifo_empty) r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  assign burst_req  = (r_state == REQ) && !r_tail;
  assign tail_req   = (r_state == REQ) &&  r_tail;
  assign burst_done = (r_state == FSH) && !r_tail;
  assign tail_done  = (r_state == FSH) &&  r_tail;
  assign frame_done = (r_state == FSH) && (r_remain == '0);
  assign rst_chain  = (r_state == TIME_ERR);
  assign busy       = (r_state != IDLE);
  assign req_len    = r_req_len;
  assign remain     = r_remain;

endmodule
